soundrive_sd_dac: RTL and testbench
===================================

// Module: soundrive_sd_dac
// PURPOSE
// Stereo mixer and 1st-order sigma-delta DAC downstream of the Soundrive/Covox latches.
// - Samples the four 8-bit channel registers plus the beeper on a periodic strobe.
// - Sums L0+L1 (+beeper) and R0+R1 (+beeper) with one shared adder in a small sequencer.
// - Drives 1-bit pulse-density outputs to the board RC filters.
// PARAMETERS
// DIV         64     clk28 cycles per mix update; legal range 8..1024 (437.5 kHz at default)
// BEEP_LEVEL  8'd255 amplitude added to both sides while beeper=1
// PORTS
// clk28    in   1   system clock, 28 MHz
// rst      in   1   asynchronous reset, active-high
// en       in   1   block enable; 0 = mute and hold idle
// beeper   in   1   beeper level
// ch_l0    in   8   left channel 0, unsigned
// ch_l1    in   8   left channel 1, unsigned
// ch_r0    in   8   right channel 0, unsigned
// ch_r1    in   8   right channel 1, unsigned
// mix_l    out  10  last committed left sum, unsigned
// mix_r    out  10  last committed right sum, unsigned
// mix_stb  out  1   one-cycle pulse on the cycle after mix_l/mix_r update
// dac_l    out  1   left sigma-delta bitstream
// dac_r    out  1   right sigma-delta bitstream
// BEHAVIOUR
// Reset (async, rst=1): all of the following go to 0 immediately:
// - divider, FSM (to IDLE), snapshot regs, partial sums
// - mix_l, mix_r, mix_stb, both sigma-delta accumulators, dac_l, dac_r
// Divider:
// - Counts 0..DIV-1 while en=1, then wraps to 0.
// - tick is asserted on the cycle count==DIV-1.
// - en=0: count held at 0, no ticks.
// Sequencer FSM: IDLE -> SNAP -> ADD_L -> ADD_R -> COMMIT -> IDLE.
// - IDLE: on tick go to SNAP.
// - SNAP: latch ch_l0, ch_l1, ch_r0, ch_r1, beeper into snapshot regs. Later input changes do not affect this sample.
// - ADD_L: sum_l = {2'b0,l0} + l1 + (beep ? BEEP_LEVEL : 0). 10-bit result, max 765, no saturation needed.
// - ADD_R: same as ADD_L for the right side, through the shared adder.
// - COMMIT: mix_l <= sum_l and mix_r <= sum_r; mix_stb=1 on the next cycle only.
// - Latency: 4 clk28 from tick to mix update; DIV>=8 guarantees no tick arrives mid-sequence.
// - A tick seen outside IDLE is ignored (defensive; unreachable for legal DIV).
// Sigma-delta (every clk28, per side, independent of the FSM):
// - {dac_x, acc_x} <= {1'b0, acc_x} + {1'b0, mix_x}; acc is 10 bits, carry drives dac.
// - Long-run density of dac_x = mix_x/1024.
// - mix_x=0 gives a constant 0 output.
// en falling (1 -> 0):
// - Within 1 cycle: FSM forced to IDLE, partial sums dropped.
// - mix_l, mix_r, acc_l, acc_r, dac_l, dac_r cleared to 0. No mix_stb.
// en rising (0 -> 1): first tick DIV cycles later; outputs stay 0 until the first COMMIT.
// Reset during any FSM state: same as power-on; no partial commit, no mix_stb.
// TESTING
// - Reset: rst pulse mid-ADD_R with ch_l0=8'hFF -> all outputs 0 asynchronously; no mix_stb.
// - Basic sum: en=1, ch_l0=8'h80, ch_l1=8'h40, ch_r0=8'h01, ch_r1=8'h00, beeper=0 -> after tick+4: mix_l=10'd192, mix_r=10'd1, one mix_stb pulse.
// - Max/beeper: all ch=8'hFF, beeper=1 -> mix_l=mix_r=10'd765; dac_l density over 1024 cycles = 765 +/-1.
// - Snapshot: change ch_l0 from 8'h10 to 8'hF0 on the ADD_L cycle, ch_l1=0 -> mix_l=10'd16; next sample gives 10'd240.
// - Density: mix_l=10'd256 -> dac_l high exactly 256 of every 1024 cycles, period-4 pattern 1000.
// - Enable: drop en mid-sequence -> next cycle mix_l=mix_r=0 and dac=0, mix_stb absent; re-raise en -> first mix_stb exactly DIV+5 cycles later.

Source files
------------

// File: rtl/soundrive_sd_dac.sv
// soundrive_sd_dac
// Stereo mixer and first-order sigma-delta DAC that sits behind the
// Soundrive/Covox channel latches.
//
// Every DIV clk28 cycles the four 8-bit channel registers and the beeper are
// captured into a snapshot. A small sequencer then forms the left and right
// sums through one shared adder and commits them to mix_l/mix_r. Two free
// running sigma-delta modulators turn the committed sums into 1-bit
// pulse-density streams for the board RC filters.
//
// Parameters
//   DIV         clk28 cycles per mix update (8..1024)
//   BEEP_LEVEL  amplitude added to both sides while the beeper is high
//
// Ports
//   clk28     in   system clock, 28 MHz
//   rst       in   asynchronous reset, active-high
//   en        in   block enable; low mutes the outputs and holds the sequencer idle
//   beeper    in   beeper level
//   ch_l0/l1  in   left channel registers, unsigned 8-bit
//   ch_r0/r1  in   right channel registers, unsigned 8-bit
//   mix_l     out  last committed left sum, unsigned 10-bit
//   mix_r     out  last committed right sum, unsigned 10-bit
//   mix_stb   out  one-cycle pulse on the cycle after mix_l/mix_r update
//   dac_l     out  left sigma-delta bitstream
//   dac_r     out  right sigma-delta bitstream

module soundrive_sd_dac #(
  parameter int unsigned DIV        = 64,
  parameter logic [7:0]  BEEP_LEVEL = 8'd255
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic       beeper,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  output logic [9:0] mix_l,
  output logic [9:0] mix_r,
  output logic       mix_stb,
  output logic       dac_l,
  output logic       dac_r
);

  localparam int unsigned     CW   = $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_ADD_L,
    S_ADD_R,
    S_COMMIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Rate divider
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          tick;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   snap_en;
  logic   load_l;
  logic   load_r;
  logic   commit;

  // Snapshot registers
  logic [7:0] snap_l0, snap_l1, snap_r0, snap_r1;
  logic       snap_beep;

  // Shared adder operands
  logic [7:0] add_a, add_b;
  logic       add_beep;
  logic [9:0] add_sum;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_en  = 1'b0;
    load_l   = 1'b0;
    load_r   = 1'b0;
    commit   = 1'b0;
    add_a    = snap_l0;
    add_b    = snap_l1;
    add_beep = snap_beep;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_SNAP;
      end
      S_SNAP: begin
        snap_en = 1'b1;
        state_d = S_ADD_L;
      end
      S_ADD_L: begin
        add_a   = snap_l0;
        add_b   = snap_l1;
        load_l  = 1'b1;
        state_d = S_ADD_R;
      end
      S_ADD_R: begin
        add_a   = snap_r0;
        add_b   = snap_r1;
        load_r  = 1'b1;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping en abandons whatever sample is in flight.
    if (!en) begin
      state_d = S_IDLE;
      snap_en = 1'b0;
      load_l  = 1'b0;
      load_r  = 1'b0;
      commit  = 1'b0;
    end
  end

  // Max 255 + 255 + 255 = 765, so 10 bits never overflow.
  assign add_sum = {2'b00, add_a} + {2'b00, add_b}
                 + (add_beep ? {2'b00, BEEP_LEVEL} : 10'd0);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      snap_l0   <= '0;
      snap_l1   <= '0;
      snap_r0   <= '0;
      snap_r1   <= '0;
      snap_beep <= 1'b0;
    end else if (snap_en) begin
      snap_l0   <= ch_l0;
      snap_l1   <= ch_l1;
      snap_r0   <= ch_r0;
      snap_r1   <= ch_r1;
      snap_beep <= beeper;
    end
  end

  // ---------------------------------------------------------------------------
  // Partial sums, committed mix and strobe
  // ---------------------------------------------------------------------------
  logic [9:0] sum_l, sum_r;
  logic       commit_q;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      sum_l    <= '0;
      sum_r    <= '0;
      mix_l    <= '0;
      mix_r    <= '0;
      commit_q <= 1'b0;
      mix_stb  <= 1'b0;
    end else if (!en) begin
      sum_l    <= '0;
      sum_r    <= '0;
      mix_l    <= '0;
      mix_r    <= '0;
      commit_q <= 1'b0;
      mix_stb  <= 1'b0;
    end else begin
      if (load_l) sum_l <= add_sum;
      if (load_r) sum_r <= add_sum;
      if (commit) begin
        mix_l <= sum_l;
        mix_r <= sum_r;
      end
      // The strobe trails the mix register by one cycle so consumers see
      // settled values whenever mix_stb is high.
      commit_q <= commit;
      mix_stb  <= commit_q;
    end
  end

  // ---------------------------------------------------------------------------
  // First-order sigma-delta modulators; the carry out of the accumulator is
  // the output bit, giving a density of mix/1024.
  // ---------------------------------------------------------------------------
  logic [9:0] acc_l, acc_r;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      acc_l <= '0;
      acc_r <= '0;
      dac_l <= 1'b0;
      dac_r <= 1'b0;
    end else if (!en) begin
      acc_l <= '0;
      acc_r <= '0;
      dac_l <= 1'b0;
      dac_r <= 1'b0;
    end else begin
      {dac_l, acc_l} <= {1'b0, acc_l} + {1'b0, mix_l};
      {dac_r, acc_r} <= {1'b0, acc_r} + {1'b0, mix_r};
    end
  end

endmodule

// File: tb/tb_soundrive_sd_dac.sv
// Self-checking bench for soundrive_sd_dac: scoreboard of expected mix sums,
// strobe latency/width, sigma-delta density, snapshot isolation, enable and
// reset behaviour.

module tb_soundrive_sd_dac;

  localparam int unsigned DIV = 64;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       en;
  logic       beeper;
  logic [7:0] ch_l0, ch_l1, ch_r0, ch_r1;
  logic [9:0] mix_l, mix_r;
  logic       mix_stb;
  logic       dac_l, dac_r;

  always #5 clk28 = ~clk28;

  soundrive_sd_dac #(
    .DIV        (DIV),
    .BEEP_LEVEL (8'd255)
  ) dut (
    .clk28   (clk28),
    .rst     (rst),
    .en      (en),
    .beeper  (beeper),
    .ch_l0   (ch_l0),
    .ch_l1   (ch_l1),
    .ch_r0   (ch_r0),
    .ch_r1   (ch_r1),
    .mix_l   (mix_l),
    .mix_r   (mix_r),
    .mix_stb (mix_stb),
    .dac_l   (dac_l),
    .dac_r   (dac_r)
  );

  int          tests = 0;
  int          fails = 0;
  int          stb_count = 0;
  logic        stb_prev = 1'b0;
  logic [19:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mix_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic bp);
    return {2'b00, a} + {2'b00, b} + (bp ? 10'd255 : 10'd0);
  endfunction

  // Strobe monitor: counts pulses and requires them to be one cycle wide.
  always @(negedge clk28) begin
    if (stb_prev) check("stb_width", {31'b0, mix_stb}, 0);
    if (mix_stb) stb_count++;
    stb_prev = mix_stb;
  end

  task automatic drive(input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] r0, input logic [7:0] r1, input logic bp);
    ch_l0  = l0;
    ch_l1  = l1;
    ch_r0  = r0;
    ch_r1  = r1;
    beeper = bp;
    sb_q.push_back({mix_model(l0, l1, bp), mix_model(r0, r1, bp)});
  endtask

  // Returns the number of rising edges until mix_stb is seen high.
  task automatic wait_stb(output int n);
    n = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(posedge clk28);
      #1;
      n++;
      if (mix_stb) return;
    end
    check("stb_timeout", 0, 1);
  endtask

  task automatic sb_check(input string tag);
    logic [19:0] e;
    check({tag, "_queued"}, {31'b0, sb_q.size() > 0}, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_mix_l"}, {22'b0, mix_l}, {22'b0, e[19:10]});
      check({tag, "_mix_r"}, {22'b0, mix_r}, {22'b0, e[9:0]});
    end
  endtask

  task automatic count_dac(output int cl, output int cr, output logic [1023:0] bits);
    cl = 0;
    cr = 0;
    bits = '0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk28);
      cl += int'(dac_l);
      cr += int'(dac_r);
      bits[i] = dac_l;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mix_l"},   {22'b0, mix_l},   0);
    check({tag, "_mix_r"},   {22'b0, mix_r},   0);
    check({tag, "_mix_stb"}, {31'b0, mix_stb}, 0);
    check({tag, "_dac_l"},   {31'b0, dac_l},   0);
    check({tag, "_dac_r"},   {31'b0, dac_r},   0);
  endtask

  initial begin
    int            n, cl, cr, bad, c0;
    logic [1023:0] bits;

    rst    = 1'b1;
    en     = 1'b0;
    beeper = 1'b0;
    ch_l0  = '0;
    ch_l1  = '0;
    ch_r0  = '0;
    ch_r1  = '0;

    // Reset state
    repeat (3) @(posedge clk28);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Basic sum and enable-to-strobe latency
    drive(8'h80, 8'h40, 8'h01, 8'h00, 1'b0);
    @(posedge clk28);
    #1 en = 1'b1;
    wait_stb(n);
    check("en_rise_latency", n, DIV + 5);
    sb_check("basic");

    // Full scale with beeper, then density of 765/1024
    wait_stb(n);
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    wait_stb(n);
    sb_check("max");
    count_dac(cl, cr, bits);
    check("density765_l", cl, 765);
    check("density765_r", cr, 765);

    // Quarter scale: exact 256/1024 with a period-4 pattern; silent right side
    wait_stb(n);
    drive(8'h80, 8'h80, 8'h00, 8'h00, 1'b0);
    wait_stb(n);
    sb_check("d256");
    count_dac(cl, cr, bits);
    check("density256_l", cl, 256);
    check("density0_r", cr, 0);
    bad = 0;
    for (int i = 0; i < 1020; i++) if (bits[i] !== bits[i+4]) bad++;
    check("period4_l", bad, 0);
    check("period4_ones", {28'b0, 3'b0, bits[0]} + bits[1] + bits[2] + bits[3], 1);

    // Snapshot isolation: ch_l0 changes during ADD_L of the next sample
    wait_stb(n);
    drive(8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (DIV - 4) @(posedge clk28);
    #1 ch_l0 = 8'hF0;
    sb_q.push_back({mix_model(8'hF0, 8'h00, 1'b0), 10'd0});
    wait_stb(n);
    sb_check("snap_old");
    wait_stb(n);
    sb_check("snap_new");

    // Enable drop during ADD_R: outputs clear next cycle, no commit
    ch_l0  = 8'hFF;
    ch_l1  = 8'hFF;
    ch_r0  = 8'hFF;
    ch_r1  = 8'hFF;
    beeper = 1'b1;
    repeat (DIV - 3) @(posedge clk28);
    check("pre_drop_mix_l", {22'b0, mix_l}, 240);
    #1 en = 1'b0;
    @(posedge clk28);
    #1;
    check_all_zero("en_drop");
    c0 = stb_count;
    repeat (3 * DIV) @(posedge clk28);
    #1;
    check("stb_while_off", stb_count, c0);
    check("mix_l_while_off", {22'b0, mix_l}, 0);

    // Re-enable: first strobe DIV+5 cycles later
    drive(8'h33, 8'h22, 8'h11, 8'h44, 1'b0);
    @(posedge clk28);
    #1 en = 1'b1;
    wait_stb(n);
    check("en_rerise_latency", n, DIV + 5);
    sb_check("after_en");

    // Asynchronous reset in the middle of ADD_R
    ch_l0 = 8'hFF;
    ch_l1 = 8'h01;
    repeat (DIV - 3) @(posedge clk28);
    check("pre_rst_mix_l", {22'b0, mix_l}, 85);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    #1 rst = 1'b0;
    c0 = stb_count;
    repeat (DIV) @(posedge clk28);
    #1;
    check("stb_after_rst", stb_count, c0);
    check("mix_l_after_rst", {22'b0, mix_l}, 0);
    sb_q.push_back({mix_model(8'hFF, 8'h01, 1'b0), mix_model(8'h11, 8'h44, 1'b0)});
    wait_stb(n);
    sb_check("post_rst");
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
